// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizes for the register-file port controller.
package rf_ctrl_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int NUM_REGS       = 2 ** ADDR_W_DEFAULT;

  typedef enum logic [1:0] {RUN, DRAIN, DBG_ACC, DBG_ACK} rf_state_e;

  typedef enum logic [1:0] {SRC_WB, SRC_LD, SRC_DBG} req_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, bit 0 never set.
// A set and a clear of the same index on one edge leave the bit set.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_addr_1,
  input  logic [ADDR_W-1:0] q_addr_2,
  output logic              q_pend_1,
  output logic              q_pend_2
);

  logic [(2**ADDR_W)-1:0] pend;
  logic [(2**ADDR_W)-1:0] set_mask;
  logic [(2**ADDR_W)-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Clear first, then OR in the set so the set wins on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~clr_mask) | set_mask;
  end

  assign q_pend_1 = pend[q_addr_1];
  assign q_pend_2 = pend[q_addr_2];

endmodule

// File: rtl/rf_port_ctrl.sv
// Register-file write-port arbiter, load scoreboard, hazard stall and debug access.
// Optional macro RF_PORT_CTRL_BYPASS_EN forwards the in-flight write to the read operands.
module rf_port_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              stall,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rf_rd_addr_1,
  output logic [ADDR_W-1:0] rf_rd_addr_2,
  input  logic [DATA_W-1:0] rf_rd_data_1,
  input  logic [DATA_W-1:0] rf_rd_data_2,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data
);

  rf_state_e state, state_next;
  req_src_e  rr_last;
  logic      wr_is_ld;
  logic      arb_ok, wb_go, ld_go, dbg_wr_go;
  logic      pend_1, pend_2, fwd_1, fwd_2, haz_1, haz_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A tie goes to whichever source did not win last.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dbg_req) state_next = DRAIN;
      DRAIN:   state_next = DBG_ACC;
      DBG_ACC: state_next = DBG_ACK;
      DBG_ACK: state_next = RUN;
      default: state_next = RUN;
    endcase
    arb_ok    = (state == RUN) && !dbg_req;
    wb_ready  = arb_ok && (!ld_valid || (rr_last != SRC_WB));
    ld_ready  = arb_ok && (!wb_valid || (rr_last != SRC_LD));
    wb_go     = wb_valid && wb_ready;
    ld_go     = ld_valid && ld_ready;
    dbg_wr_go = (state == DBG_ACC) && dbg_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      wr_is_ld   <= 1'b0;
      rr_last    <= SRC_LD;
    end else begin
      rf_wr_en <= 1'b0;
      wr_is_ld <= 1'b0;
      if (wb_go) begin
        rf_wr_en   <= (wb_addr != '0);
        rf_wr_addr <= wb_addr;
        rf_wr_data <= wb_data;
        rr_last    <= SRC_WB;
      end else if (ld_go) begin
        rf_wr_en   <= (ld_addr != '0);
        rf_wr_addr <= ld_addr;
        rf_wr_data <= ld_data;
        wr_is_ld   <= 1'b1;
        rr_last    <= SRC_LD;
      end else if (dbg_wr_go) begin
        rf_wr_en   <= (dbg_addr != '0);
        rf_wr_addr <= dbg_addr;
        rf_wr_data <= dbg_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= (state == DBG_ACC);
      if ((state == DBG_ACC) && !dbg_we) dbg_rdata <= rf_rd_data_1;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sb_set),
    .set_addr (sb_addr),
    .clr_en   (rf_wr_en && wr_is_ld),
    .clr_addr (rf_wr_addr),
    .q_addr_1 (rs1_addr),
    .q_addr_2 (rs2_addr),
    .q_pend_1 (pend_1),
    .q_pend_2 (pend_2)
  );

  assign rf_rd_addr_1 = (state == DBG_ACC) ? dbg_addr : rs1_addr;
  assign rf_rd_addr_2 = rs2_addr;

  assign fwd_1 = rf_wr_en && (rs1_addr != '0) && (rf_wr_addr == rs1_addr);
  assign fwd_2 = rf_wr_en && (rs2_addr != '0) && (rf_wr_addr == rs2_addr);

`ifdef RF_PORT_CTRL_BYPASS_EN
  // A load sitting in rf_wr_* is forwarded, so its scoreboard bit no longer blocks.
  assign haz_1    = (rs1_addr != '0) && pend_1 && !(fwd_1 && wr_is_ld);
  assign haz_2    = (rs2_addr != '0) && pend_2 && !(fwd_2 && wr_is_ld);
  assign rs1_data = fwd_1 ? rf_wr_data : rf_rd_data_1;
  assign rs2_data = fwd_2 ? rf_wr_data : rf_rd_data_2;
`else
  assign haz_1    = (rs1_addr != '0) && (pend_1 || fwd_1);
  assign haz_2    = (rs2_addr != '0) && (pend_2 || fwd_2);
  assign rs1_data = rf_rd_data_1;
  assign rs2_data = rf_rd_data_2;
`endif

  assign stall = (state != RUN) || dbg_req || haz_1 || haz_2;

endmodule
